// File: rtl/da_serial_mac_if.sv
// Bus between the 3-tap distributed-arithmetic MAC and its requester/ROM.
// The master drives samples, start and the ROM response; the slave is the MAC.
interface da_serial_mac_if #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = DATA_WIDTH + 5
);
  logic                           start;
  logic signed [DATA_WIDTH-1:0]   x0;
  logic signed [DATA_WIDTH-1:0]   x1;
  logic signed [DATA_WIDTH-1:0]   x2;
  logic [2:0]                     rom_addr;
  logic signed [5:0]              rom_data;
  logic                           busy;
  logic signed [RESULT_WIDTH-1:0] result;
  logic                           result_valid;

  modport master (
    output start, x0, x1, x2, rom_data,
    input  rom_addr, busy, result, result_valid
  );

  modport slave (
    input  start, x0, x1, x2, rom_data,
    output rom_addr, busy, result, result_valid
  );
endinterface

// File: rtl/da_serial_mac.sv
// Bit-serial 3-tap distributed-arithmetic MAC: MSB-first walk over the samples,
// one external ROM lookup per bit, sign bit weighted negatively.
module da_serial_mac #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = DATA_WIDTH + 5
) (
  input logic            clk,
  input logic            rst_n,
  da_serial_mac_if.slave bus
);

  localparam int unsigned MSB   = DATA_WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                         state;
  logic [DATA_WIDTH-1:0]          sr0;
  logic [DATA_WIDTH-1:0]          sr1;
  logic [DATA_WIDTH-1:0]          sr2;
  logic [CNT_W-1:0]               cnt;
  logic signed [RESULT_WIDTH-1:0] acc;
  logic signed [RESULT_WIDTH-1:0] result;
  logic                           result_valid;
  logic [2:0]                     rom_addr;

  logic signed [RESULT_WIDTH-1:0] rom_ext;
  logic signed [RESULT_WIDTH-1:0] acc_next;

  // Sign bit contributes with negative weight; later bits double-and-add.
  always_comb begin
    rom_ext  = RESULT_WIDTH'(bus.rom_data);
    acc_next = (acc <<< 1) + rom_ext;
    if (cnt == CNT_W'(MSB)) begin
      acc_next = RESULT_WIDTH'(0) - rom_ext;
    end
  end

  // rom_addr is registered as the MSBs the shift registers will hold next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sr0          <= '0;
      sr1          <= '0;
      sr2          <= '0;
      cnt          <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      rom_addr     <= 3'b000;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr0      <= bus.x0;
            sr1      <= bus.x1;
            sr2      <= bus.x2;
            acc      <= '0;
            cnt      <= CNT_W'(MSB);
            rom_addr <= {bus.x2[MSB], bus.x1[MSB], bus.x0[MSB]};
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          sr0 <= sr0 << 1;
          sr1 <= sr1 << 1;
          sr2 <= sr2 << 1;
          if (cnt == '0) begin
            result       <= acc_next;
            result_valid <= 1'b1;
            rom_addr     <= 3'b000;
            state        <= IDLE;
          end else begin
            cnt      <= cnt - CNT_W'(1);
            rom_addr <= {sr2[MSB-1], sr1[MSB-1], sr0[MSB-1]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state == RUN);
  assign bus.rom_addr     = rom_addr;
  assign bus.result       = result;
  assign bus.result_valid = result_valid;

endmodule

// File: tb/tb_da_serial_mac.sv
// Self-checking bench for da_serial_mac: behavioural ROM, arithmetic reference
// sums, and scenario tasks for reset, known vectors, random, abort and streaming.
module tb_da_serial_mac;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = DW + 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic signed [5:0] coef [3];

  da_serial_mac_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus ();

  da_serial_mac #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DA ROM: entry for an address is the sum of the coefficients whose bit is set.
  function automatic logic signed [5:0] rom_of(input logic [2:0] a,
      input logic signed [5:0] c0, input logic signed [5:0] c1, input logic signed [5:0] c2);
    int s;
    s = 0;
    if (a[0]) s += int'(c0);
    if (a[1]) s += int'(c1);
    if (a[2]) s += int'(c2);
    return 6'(s);
  endfunction

  assign bus.rom_data = rom_of(bus.rom_addr, coef[0], coef[1], coef[2]);

  function automatic logic signed [RW-1:0] exp_sum(input int c0, input int c1, input int c2,
      input int v0, input int v1, input int v2);
    return RW'(c0 * v0 + c1 * v1 + c2 * v2);
  endfunction

  // Address expected in RUN cycle j: bit (DW-1-j) of each sample, tap k on bit k.
  function automatic logic [2:0] exp_addr(input int v0, input int v1, input int v2, input int j);
    logic [DW-1:0] a, b, d;
    a = DW'(v0);
    b = DW'(v1);
    d = DW'(v2);
    return {d[DW-1-j], b[DW-1-j], a[DW-1-j]};
  endfunction

  // Observations of the most recent computation.
  logic [2:0]        o_addr [DW];
  int                o_busy;
  int                o_valid_run;
  bit                o_result_stable;
  logic              o_busy_after;
  logic              o_valid;
  logic signed [RW-1:0] o_result;
  int                o_valid_cyc;

  // Drives one computation from a negedge in IDLE and records what it sees;
  // ends at the negedge of the result_valid cycle. Samples are scrambled during RUN.
  task automatic run_calc(input int c0, input int c1, input int c2,
                          input int v0, input int v1, input int v2,
                          input bit hold, input int disturb_at);
    logic signed [RW-1:0] prev;
    coef[0] = 6'(c0);
    coef[1] = 6'(c1);
    coef[2] = 6'(c2);
    bus.x0 = DW'(v0);
    bus.x1 = DW'(v1);
    bus.x2 = DW'(v2);
    bus.start = 1'b1;
    @(negedge clk);
    o_busy = 0;
    o_valid_run = 0;
    o_result_stable = 1'b1;
    prev = bus.result;
    for (int j = 0; j < int'(DW); j++) begin
      o_addr[j] = bus.rom_addr;
      if (bus.busy === 1'b1) o_busy++;
      if (bus.result_valid !== 1'b0) o_valid_run++;
      if (bus.result !== prev) o_result_stable = 1'b0;
      bus.start = hold;
      bus.x0 = DW'($urandom);
      bus.x1 = DW'($urandom);
      bus.x2 = DW'($urandom);
      if (j == disturb_at) begin
        bus.start = 1'b1;
        bus.x0 = DW'(5);
        bus.x1 = DW'(5);
        bus.x2 = DW'(5);
      end
      @(negedge clk);
    end
    o_busy_after = bus.busy;
    o_valid      = bus.result_valid;
    o_result     = bus.result;
    o_valid_cyc  = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.x0 = DW'(1);
    bus.x1 = DW'(2);
    bus.x2 = DW'(3);
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.result_valid); end
    checks++; if (bus.result !== RW'(0)) begin errors++; $display("FAIL reset_result got %0d want 0", bus.result); end
    checks++; if (bus.rom_addr !== 3'b000) begin errors++; $display("FAIL reset_rom_addr got %b want 000", bus.rom_addr); end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_known();
    int tv [5][7] = '{
      '{ 1,  1,  1,    1,    2,    3,     6},
      '{-8,  7,  3, -128,  127,   -1,  1910},
      '{-8, -8, -8, -128, -128, -128,  3072},
      '{-8, -8, -8,  127,  127,  127, -3048},
      '{ 1,  2,  4,    1,    0,    0,     1}};
    for (int t = 0; t < 5; t++) begin
      run_calc(tv[t][0], tv[t][1], tv[t][2], tv[t][3], tv[t][4], tv[t][5], 1'b0, -1);
      checks++; if (o_result !== RW'(tv[t][6])) begin errors++; $display("FAIL known_result[%0d] got %0d want %0d", t, o_result, tv[t][6]); end
      checks++; if (o_busy != int'(DW)) begin errors++; $display("FAIL known_busy_cycles[%0d] got %0d want %0d", t, o_busy, DW); end
      checks++; if (o_valid !== 1'b1 || o_valid_run != 0) begin errors++; $display("FAIL known_valid[%0d] got %b/%0d want 1/0", t, o_valid, o_valid_run); end
      checks++; if (o_busy_after !== 1'b0) begin errors++; $display("FAIL known_busy_after[%0d] got %b want 0", t, o_busy_after); end
      for (int j = 0; j < int'(DW); j++) begin
        checks++;
        if (o_addr[j] !== exp_addr(tv[t][3], tv[t][4], tv[t][5], j)) begin
          errors++;
          $display("FAIL known_rom_addr[%0d][%0d] got %b want %b", t, j, o_addr[j], exp_addr(tv[t][3], tv[t][4], tv[t][5], j));
        end
      end
    end
  endtask

  task automatic test_rom_addr();
    run_calc(1, 2, 4, 1, 0, 0, 1'b0, -1);
    checks++; if (o_addr[0] !== 3'b000) begin errors++; $display("FAIL addr_first got %b want 000", o_addr[0]); end
    checks++; if (o_addr[DW-1] !== 3'b001) begin errors++; $display("FAIL addr_last got %b want 001", o_addr[DW-1]); end
    checks++; if (o_result !== RW'(1)) begin errors++; $display("FAIL addr_result got %0d want 1", o_result); end
    @(negedge clk);
    checks++; if (bus.rom_addr !== 3'b000) begin errors++; $display("FAIL addr_idle got %b want 000", bus.rom_addr); end
  endtask

  task automatic test_random();
    int c [3];
    int v [3];
    logic signed [RW-1:0] e;
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 3; k++) begin
        c[k] = int'($urandom_range(15)) - 8;
        v[k] = int'($urandom_range(255)) - 128;
      end
      e = exp_sum(c[0], c[1], c[2], v[0], v[1], v[2]);
      run_calc(c[0], c[1], c[2], v[0], v[1], v[2], 1'b0, -1);
      checks++; if (o_result !== e) begin errors++; $display("FAIL rand_result[%0d] got %0d want %0d", n, o_result, e); end
      checks++; if (o_valid !== 1'b1 || o_busy != int'(DW)) begin errors++; $display("FAIL rand_timing[%0d] got valid %b busy %0d want 1/%0d", n, o_valid, o_busy, DW); end
      for (int j = 0; j < int'(DW); j++) begin
        checks++;
        if (o_addr[j] !== exp_addr(v[0], v[1], v[2], j)) begin
          errors++;
          $display("FAIL rand_rom_addr[%0d][%0d] got %b want %b", n, j, o_addr[j], exp_addr(v[0], v[1], v[2], j));
        end
      end
      if ((n % 3) == 0) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    run_calc(3, -5, 7, 1, 2, 3, 1'b0, 3);
    checks++; if (o_result !== RW'(14)) begin errors++; $display("FAIL ign_result got %0d want 14", o_result); end
    checks++; if (o_valid_run != 0 || o_valid !== 1'b1) begin errors++; $display("FAIL ign_valid got %0d/%b want 0/1", o_valid_run, o_valid); end
    checks++; if (o_result_stable !== 1'b1) begin errors++; $display("FAIL ign_result_stable got %b want 1", o_result_stable); end
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ign_after got valid %b busy %b want 0/0", bus.result_valid, bus.busy); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    coef[0] = 6'(1);
    coef[1] = 6'(1);
    coef[2] = 6'(1);
    bus.x0 = DW'(1);
    bus.x1 = DW'(2);
    bus.x2 = DW'(3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b want 1", bus.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    checks++; if (bus.result !== RW'(0)) begin errors++; $display("FAIL abort_result got %0d want 0", bus.result); end
    checks++; if (bus.rom_addr !== 3'b000) begin errors++; $display("FAIL abort_rom_addr got %b want 000", bus.rom_addr); end
    rst_n = 1'b1;
    pulses = 0;
    repeat (DW + 2) begin
      if (bus.result_valid !== 1'b0) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_pulse got %0d want 0", pulses); end
    run_calc(1, 1, 1, 1, 2, 3, 1'b0, -1);
    checks++; if (o_result !== RW'(6)) begin errors++; $display("FAIL abort_restart got %0d want 6", o_result); end
  endtask

  task automatic test_back_to_back();
    int c [3];
    int v [3];
    int vcyc [3];
    logic signed [RW-1:0] e;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 3; k++) begin
        c[k] = int'($urandom_range(15)) - 8;
        v[k] = int'($urandom_range(255)) - 128;
      end
      e = exp_sum(c[0], c[1], c[2], v[0], v[1], v[2]);
      run_calc(c[0], c[1], c[2], v[0], v[1], v[2], (n < 2), -1);
      vcyc[n] = o_valid_cyc;
      checks++; if (o_result !== e || o_valid !== 1'b1) begin errors++; $display("FAIL b2b_result[%0d] got %0d/%b want %0d/1", n, o_result, o_valid, e); end
      if (n > 0) begin
        checks++;
        if (vcyc[n] - vcyc[n-1] != int'(DW) + 1) begin
          errors++;
          $display("FAIL b2b_spacing[%0d] got %0d want %0d", n, vcyc[n] - vcyc[n-1], DW + 1);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x0 = '0;
    bus.x1 = '0;
    bus.x2 = '0;
    coef[0] = '0;
    coef[1] = '0;
    coef[2] = '0;
    rst_n = 1'b0;
    test_reset();
    test_known();
    test_rom_addr();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
